// File: rtl/pot_scan_sequencer.sv
// Round-robin scheduler sharing one A2D master among six slide pots; captures
// each 12-bit result into a per-slot gain register with paced, watchdogged requests.
module pot_scan_sequencer #(
  parameter int unsigned GAP_CYC     = 16,
  parameter int unsigned TIMEOUT_CYC = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [5:0]  band_mask,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [11:0] lp_gain,
  output logic [11:0] b1_gain,
  output logic [11:0] b2_gain,
  output logic [11:0] b3_gain,
  output logic [11:0] hp_gain,
  output logic [11:0] volume,
  output logic        upd_vld,
  output logic [2:0]  upd_idx,
  output logic        scan_done,
  output logic        timeout_err,
  input  logic        clr_err
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SEL, START, WAIT, GAP} state_t;

  state_t        state, state_n;
  logic [2:0]    ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          is_last;
  logic          sel_hit, capture, wd_expire;
  logic [11:0]   gain_q [6];

  function automatic logic [2:0] chan_of(input logic [2:0] slot);
    logic [2:0] ch;
    case (slot)
      3'd0:    ch = 3'd1;
      3'd1:    ch = 3'd0;
      3'd2:    ch = 3'd4;
      3'd3:    ch = 3'd2;
      3'd4:    ch = 3'd3;
      3'd5:    ch = 3'd7;
      default: ch = 3'd0;
    endcase
    return ch;
  endfunction

  function automatic logic [2:0] top_slot(input logic [5:0] m);
    logic [2:0] t;
    t = '0;
    for (int unsigned i = 0; i < 6; i++)
      if (m[i]) t = 3'(i);
    return t;
  endfunction

  function automatic logic [2:0] next_ptr(input logic [2:0] p);
    return (p == 3'd5) ? 3'd0 : p + 3'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  // One counter serves as watchdog in WAIT and as pacing timer in GAP.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    sel_hit   = 1'b0;
    capture   = 1'b0;
    wd_expire = 1'b0;
    case (state)
      IDLE: begin
        ptr_n = '0;
        cnt_n = '0;
        if (en && (band_mask != '0)) state_n = SEL;
      end
      SEL: begin
        if (band_mask == '0) begin
          state_n = IDLE;
          ptr_n   = '0;
        end else if (band_mask[ptr]) begin
          sel_hit = 1'b1;
          state_n = START;
        end else begin
          ptr_n = next_ptr(ptr);
        end
      end
      START: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (cnv_cmplt) begin
          capture = 1'b1;
          cnt_n   = '0;
          state_n = GAP;
        end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          wd_expire = 1'b1;
          cnt_n     = '0;
          state_n   = GAP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYC - 1)) begin
          cnt_n = '0;
          if (en && (band_mask != '0)) begin
            state_n = SEL;
            ptr_n   = next_ptr(ptr);
          end else begin
            state_n = IDLE;
            ptr_n   = '0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        ptr_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strt_cnv    <= 1'b0;
      chnnl       <= '0;
      is_last     <= 1'b0;
      upd_vld     <= 1'b0;
      upd_idx     <= '0;
      scan_done   <= 1'b0;
      timeout_err <= 1'b0;
      for (int unsigned i = 0; i < 6; i++) gain_q[i] <= 12'h800;
    end else begin
      strt_cnv  <= sel_hit;
      upd_vld   <= capture;
      scan_done <= (capture || wd_expire) && is_last;
      if (sel_hit) begin
        chnnl   <= chan_of(ptr);
        is_last <= (ptr == top_slot(band_mask));
      end
      if (capture) upd_idx <= ptr;
      for (int unsigned i = 0; i < 6; i++)
        if (capture && (ptr == 3'(i))) gain_q[i] <= res;
      // A timeout in the same cycle as clr_err keeps the flag set.
      timeout_err <= wd_expire | (timeout_err & ~clr_err);
    end
  end

  assign lp_gain = gain_q[0];
  assign b1_gain = gain_q[1];
  assign b2_gain = gain_q[2];
  assign b3_gain = gain_q[3];
  assign hp_gain = gain_q[4];
  assign volume  = gain_q[5];

endmodule
